// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: FSM state encoding and SCLK edge selection.
package spi_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } spi_state_e;

   // Data is sampled on the rising SCLK edge exactly when CPOL and CPHA agree.
   function automatic bit sample_on_rise(input bit cpol, input bit cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Resynchronises SCLK/MOSI/SS_n into the clk domain and flags sample/shift edges
// and slave-select transitions as single-cycle pulses.
module spi_edge_sync
   import spi_pkg::*;
#(
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic mosi,
   input  logic ss_n,
   output logic mosi_s,
   output logic sample_edge,
   output logic shift_edge,
   output logic ss_fall,
   output logic ss_rise
);

   localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
   logic                   sclk_prev_q, ss_prev_q;
   logic                   sclk_s, ss_s, sclk_rise, sclk_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q      <= {SYNC_STAGES{CPOL}};
         mosi_q      <= '0;
         ss_q        <= '1;
         sclk_prev_q <= CPOL;
         ss_prev_q   <= 1'b1;
      end else begin
         sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
         mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
         ss_q        <= {ss_q[SYNC_STAGES-2:0], ss_n};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
      end
   end

   assign sclk_s      = sclk_q[SYNC_STAGES-1];
   assign ss_s        = ss_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_q[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
   assign ss_fall     = ~ss_s & ss_prev_q;
   assign ss_rise     = ss_s & ~ss_prev_q;

endmodule

// File: rtl/spi_slave_mode.sv
// Full-duplex SPI slave with configurable width, bit order and mode.
// Define SPI_SLAVE_ERR_EN to add the tx_underrun and frame_err pulse outputs.
module spi_slave_mode
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SCLK,
   input  logic              MOSI,
   input  logic              SS_n,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_done,
   output logic              busy
`ifdef SPI_SLAVE_ERR_EN
   ,
   output logic              tx_underrun,
   output logic              frame_err
`endif
);

   localparam int unsigned      CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic mosi_s, sample_edge, shift_edge, ss_fall, ss_rise;

   spi_edge_sync #(
      .CPOL        (CPOL),
      .CPHA        (CPHA),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk        (SCLK),
      .mosi        (MOSI),
      .ss_n        (SS_n),
      .mosi_s      (mosi_s),
      .sample_edge (sample_edge),
      .shift_edge  (shift_edge),
      .ss_fall     (ss_fall),
      .ss_rise     (ss_rise)
   );

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, tx_buf_q, tx_buf_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d, rx_shift, tx_shift;
   logic              tx_full_q, tx_full_d, rx_done_q, rx_done_d;
   logic              first_q, first_d, reload_q, reload_d, load;

   assign rx_shift = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr_q[DATA_W-1:1]};
   assign tx_shift = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_W-1:1]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_sr_d   = rx_sr_q;
      tx_sr_d   = tx_sr_q;
      tx_buf_d  = tx_buf_q;
      tx_full_d = tx_full_q;
      rx_data_d = rx_data_q;
      rx_done_d = 1'b0;
      first_d   = first_q;
      reload_d  = 1'b0;
      load      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = XFER;
               cnt_d   = '0;
               rx_sr_d = '0;
               load    = 1'b1;
            end
         end
         XFER: begin
            if (ss_rise) begin
               state_d = IDLE;
               cnt_d   = '0;
               rx_sr_d = '0;
               tx_sr_d = '0;
               first_d = 1'b0;
            end else begin
               if (sample_edge) begin
                  rx_sr_d = rx_shift;
                  if (cnt_q == LAST_BIT) begin
                     cnt_d     = '0;
                     rx_data_d = rx_shift;
                     rx_done_d = 1'b1;
                     reload_d  = CPHA;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               // In CPHA=0 a shift edge with the counter at zero can only follow a
               // completed word, so it starts the next back-to-back frame.
               if (shift_edge) begin
                  if (!CPHA && cnt_q == '0) begin
                     load = 1'b1;
                  end else if (CPHA && first_q) begin
                     first_d = 1'b0;
                  end else begin
                     tx_sr_d = tx_shift;
                  end
               end
               if (reload_q) begin
                  load = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         first_d   = 1'b1;
         tx_sr_d   = tx_full_q ? tx_buf_q : '0;
         tx_full_d = 1'b0;
      end
      // A write racing a load into an empty buffer is kept for the following frame.
      if (tx_valid && !tx_full_q) begin
         tx_buf_d  = tx_data;
         tx_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rx_sr_q   <= '0;
         tx_sr_q   <= '0;
         tx_buf_q  <= '0;
         tx_full_q <= 1'b0;
         rx_data_q <= '0;
         rx_done_q <= 1'b0;
         first_q   <= 1'b0;
         reload_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_sr_q   <= rx_sr_d;
         tx_sr_q   <= tx_sr_d;
         tx_buf_q  <= tx_buf_d;
         tx_full_q <= tx_full_d;
         rx_data_q <= rx_data_d;
         rx_done_q <= rx_done_d;
         first_q   <= first_d;
         reload_q  <= reload_d;
      end
   end

   assign MISO     = (state_q == XFER) && (MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0]);
   assign tx_ready = ~tx_full_q;
   assign rx_data  = rx_data_q;
   assign rx_done  = rx_done_q;
   assign busy     = (state_q == XFER);

`ifdef SPI_SLAVE_ERR_EN
   logic underrun_q, frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         underrun_q  <= load && !tx_full_q;
         frame_err_q <= (state_q == XFER) && ss_rise && (cnt_q != '0);
      end
   end

   assign tx_underrun = underrun_q;
   assign frame_err   = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: a mode-0 8-bit MSB-first instance and a mode-3 16-bit LSB-first
// instance driven by a behavioural SPI master that also captures MISO.
module tb_spi_slave_mode;

   localparam int H = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sclk_p = 2'b10;
   logic [1:0]  mosi_p = 2'b00;
   logic [1:0]  ss_p = 2'b11;
   logic [1:0]  txv = 2'b00;
   logic [7:0]  txd0 = '0;
   logic [15:0] txd1 = '0;
   logic        miso0, miso1, rdy0, rdy1, done0, done1, busy0, busy1;
   logic [7:0]  rxd0;
   logic [15:0] rxd1;
   int          checks = 0, failures = 0;
   int          ndone0 = 0, ndone1 = 0, nund0 = 0, nund1 = 0, nferr0 = 0;
   logic [15:0] rxq1[$];
   logic        busy_mid, rdy_mid;
`ifdef SPI_SLAVE_ERR_EN
   logic        und0, und1, ferr0, ferr1;
`endif

   spi_slave_mode #(
      .DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[0]), .MOSI(mosi_p[0]), .SS_n(ss_p[0]),
      .MISO(miso0), .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(rdy0),
      .rx_data(rxd0), .rx_done(done0), .busy(busy0)
`ifdef SPI_SLAVE_ERR_EN
      , .tx_underrun(und0), .frame_err(ferr0)
`endif
   );

   spi_slave_mode #(
      .DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(3)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk_p[1]), .MOSI(mosi_p[1]), .SS_n(ss_p[1]),
      .MISO(miso1), .tx_data(txd1), .tx_valid(txv[1]), .tx_ready(rdy1),
      .rx_data(rxd1), .rx_done(done1), .busy(busy1)
`ifdef SPI_SLAVE_ERR_EN
      , .tx_underrun(und1), .frame_err(ferr1)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done0) ndone0++;
      if (done1) begin
         ndone1++;
         rxq1.push_back(rxd1);
      end
`ifdef SPI_SLAVE_ERR_EN
      if (und0) nund0++;
      if (und1) nund1++;
      if (ferr0) nferr0++;
`endif
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx(input int which, input logic [15:0] d);
      if (which == 1) txd1 = d;
      else txd0 = d[7:0];
      txv[which] = 1'b1;
      @(negedge clk);
      txv[which] = 1'b0;
   endtask

   // Master: nw words under one SS_n low; stop_bits>0 aborts the first word after that many bits.
   task automatic spi_frame(input int which, input int nw, input logic [15:0] wa,
                            input logic [15:0] wb, input int stop_bits,
                            output logic [15:0] ra, output logic [15:0] rb);
      int          n, idx;
      logic        cp;
      logic [15:0] w, r;
      bit          stop;
      n  = (which == 1) ? 16 : 8;
      cp = (which == 1);
      ra = '0;
      rb = '0;
      stop = 1'b0;
      ss_p[which] = 1'b0;
      for (int f = 0; f < nw && !stop; f++) begin
         w = (f == 0) ? wa : wb;
         r = '0;
         for (int k = 0; k < n; k++) begin
            if (stop_bits > 0 && k == stop_bits) begin
               stop = 1'b1;
               break;
            end
            idx = cp ? k : n - 1 - k;
            if (!cp) begin
               mosi_p[which] = w[idx];
               wait_clk(H);
               sclk_p[which] = 1'b1;
               r[idx] = miso0;
               wait_clk(H);
               sclk_p[which] = 1'b0;
            end else begin
               wait_clk(H);
               sclk_p[which] = 1'b0;
               mosi_p[which] = w[idx];
               wait_clk(H);
               sclk_p[which] = 1'b1;
               r[idx] = miso1;
            end
            if (f == 0 && k == 0) begin
               busy_mid = cp ? busy1 : busy0;
               rdy_mid  = cp ? rdy1 : rdy0;
            end
         end
         if (f == 0) ra = r;
         else rb = r;
      end
      wait_clk(H);
      ss_p[which] = 1'b1;
      mosi_p[which] = 1'b0;
      wait_clk(H);
   endtask

   initial begin
      logic [15:0] ra, rb, w, t, t2, w2;
      logic [7:0]  dir_words[4];
      logic [7:0]  last_rx;
      int          n0, nu, nf;
      bit          use_tx;
      dir_words = '{8'hF0, 8'h0F, 8'hAA, 8'h55};

      wait_clk(3);
      check_eq("rst_miso0", miso0, 0);
      check_eq("rst_ready0", rdy0, 1);
      check_eq("rst_rxdata0", rxd0, 0);
      check_eq("rst_done0", done0, 0);
      check_eq("rst_busy0", busy0, 0);
      check_eq("rst_ready1", rdy1, 1);
      rst_n = 1'b1;
      wait_clk(5);

      foreach (dir_words[i]) begin
         n0 = ndone0;
         nu = nund0;
         spi_frame(0, 1, {8'h00, dir_words[i]}, 16'h0, 0, ra, rb);
         check_eq("rx_word", rxd0, dir_words[i]);
         check_eq("rx_done_once", ndone0 - n0, 1);
         check_eq("busy_in_frame", busy_mid, 1);
         check_eq("busy_after", busy0, 0);
         check_eq("miso_zeros", ra, 0);
`ifdef SPI_SLAVE_ERR_EN
         check_eq("underrun_pulse", nu + 1, nund0);
`endif
      end

      write_tx(0, 16'h003C);
      check_eq("tx_ready_fall", rdy0, 0);
      nu = nund0;
      spi_frame(0, 1, 16'h00A5, 16'h0, 0, ra, rb);
      check_eq("miso_3c", ra, 16'h003C);
      check_eq("rx_a5", rxd0, 8'hA5);
      check_eq("tx_ready_at_start", rdy_mid, 1);
`ifdef SPI_SLAVE_ERR_EN
      check_eq("no_underrun", nund0, nu);
`endif

      for (int i = 0; i < 6; i++) begin
         w = 16'($urandom_range(0, 255));
         t = 16'($urandom_range(0, 255));
         use_tx = 1'($urandom_range(0, 1));
         if (use_tx) write_tx(0, t);
         n0 = ndone0;
         spi_frame(0, 1, w, 16'h0, 0, ra, rb);
         check_eq("rand_rx", rxd0, w);
         check_eq("rand_miso", ra, use_tx ? t : 16'h0);
         check_eq("rand_done", ndone0 - n0, 1);
         last_rx = w[7:0];
      end

      // Abort after 5 bits; a word written mid-frame must survive for the next frame.
      n0 = ndone0;
      nf = nferr0;
      fork
         spi_frame(0, 1, 16'h00FF, 16'h0, 5, ra, rb);
         begin
            wait_clk(3 * H);
            write_tx(0, 16'h0096);
         end
      join
      check_eq("abort_no_done", ndone0 - n0, 0);
      check_eq("abort_rx_held", rxd0, last_rx);
      check_eq("abort_buf_kept", rdy0, 0);
`ifdef SPI_SLAVE_ERR_EN
      check_eq("frame_err", nferr0 - nf, 1);
`endif
      n0 = ndone0;
      spi_frame(0, 1, 16'h0081, 16'h0, 0, ra, rb);
      check_eq("after_abort_rx", rxd0, 8'h81);
      check_eq("after_abort_miso", ra, 16'h0096);
      check_eq("after_abort_done", ndone0 - n0, 1);

      rxq1.delete();
      nu = nund1;
      write_tx(1, 16'h1234);
      fork
         spi_frame(1, 2, 16'hCAFE, 16'h0001, 0, ra, rb);
         begin
            wait_clk(4 * H);
            write_tx(1, 16'hBEEF);
         end
      join
      check_eq("m3_miso_a", ra, 16'h1234);
      check_eq("m3_miso_b", rb, 16'hBEEF);
      check_eq("m3_done_cnt", rxq1.size(), 2);
      if (rxq1.size() == 2) begin
         check_eq("m3_rx_a", rxq1[0], 16'hCAFE);
         check_eq("m3_rx_b", rxq1[1], 16'h0001);
      end
`ifdef SPI_SLAVE_ERR_EN
      check_eq("m3_no_underrun", nund1, nu);
`endif

      for (int i = 0; i < 2; i++) begin
         rxq1.delete();
         w  = 16'($urandom);
         w2 = 16'($urandom);
         t  = 16'($urandom);
         t2 = 16'($urandom);
         write_tx(1, t);
         fork
            spi_frame(1, 2, w, w2, 0, ra, rb);
            begin
               wait_clk(4 * H);
               write_tx(1, t2);
            end
         join
         check_eq("m3r_miso_a", ra, t);
         check_eq("m3r_miso_b", rb, t2);
         check_eq("m3r_done_cnt", rxq1.size(), 2);
         if (rxq1.size() == 2) begin
            check_eq("m3r_rx_a", rxq1[0], w);
            check_eq("m3r_rx_b", rxq1[1], w2);
         end
      end

      write_tx(0, 16'h00FF);
      fork
         spi_frame(0, 1, 16'h00C3, 16'h0, 0, ra, rb);
         begin
            wait_clk(5 * H + 10);
            rst_n = 1'b0;
            #1;
            check_eq("mid_rst_miso", miso0, 0);
            check_eq("mid_rst_busy", busy0, 0);
            check_eq("mid_rst_rxdata", rxd0, 0);
            check_eq("mid_rst_ready", rdy0, 1);
            check_eq("mid_rst_done", done0, 0);
         end
      join
      rst_n = 1'b1;
      wait_clk(10);
      n0 = ndone0;
      spi_frame(0, 1, 16'h005A, 16'h0, 0, ra, rb);
      check_eq("post_rst_rx", rxd0, 8'h5A);
      check_eq("post_rst_done", ndone0 - n0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_mode.md
# spi_slave_mode

Parametrised SPI slave: configurable word width, bit order and SPI mode (CPOL/CPHA), with full-duplex transmit. The serial pins (SCLK, MOSI, SS_n) are oversampled and resynchronised into the system clock domain. A ready/valid transmit buffer feeds MISO, and received words are presented with a one-cycle done strobe. The block sits between the external SPI pins and the register/peripheral fabric, as the generalised successor of the fixed mode-0, 8-bit, receive-only slave.

## Interface
- DATA_W, 8: bits per frame, ≥2
- CPOL, 0: SCLK idle level
- CPHA, 0: 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
- MSB_FIRST, 1: 1 = MSB first on both MOSI and MISO; 0 = LSB first
- SYNC_STAGES, 2: synchroniser depth for SCLK, MOSI, SS_n, ≥2
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- SCLK  in  1  serial clock from master, asynchronous
- MOSI  in  1  serial data from master
- SS_n  in  1  slave select, active low
- MISO  out  1  serial data to master
- tx_data  in  DATA_W  word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmit buffer empty
- rx_data  out  DATA_W  last completed received word, held until next completion
- rx_done  out  1  one-cycle pulse when rx_data updates
- busy  out  1  frame in progress (state XFER)

## Operation
- Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- FSM states:
  - IDLE → XFER on synchronised SS_n fall: bit counter cleared, TX shift register loaded from tx_buf if full (buffer then empties), else all-zeros.
  - XFER → IDLE on synchronised SS_n rise.
- Sample edge: MOSI shifted into the RX shift register per MSB_FIRST; bit counter increments. On the DATA_W-th sample: rx_data ← assembled word, rx_done pulses, counter wraps to 0.
- Shift edge: TX shift register advances; MISO always equals its current output bit (MSB or LSB per MSB_FIRST).
  - CPHA=1: the first shift edge of each frame does not advance the register; the first bit is already on MISO from the load.
- Back-to-back frames with SS_n held low: the TX register reloads (tx_buf or zeros) in place of the shift.
  - CPHA=0: reload at the trailing edge following the last sample.
  - CPHA=1: reload in the cycle after the last sample; the next leading edge is treated as the first shift edge of the new frame.
- Transmit buffer: tx_ready = tx_buf empty; a word is accepted when tx_valid && tx_ready. If the buffer is empty and a write lands in the same cycle as a reload, the word is stored for the following frame and the current frame sends zeros.
- SS_n rising mid-frame: abort. No rx_done, counter cleared, partial RX/TX shift contents discarded, rx_data unchanged, tx_buf retained.
- MISO = 0 in IDLE.
- rst_n low, mid-frame or otherwise, immediately returns all state to reset values.

## Timing
- Reset values: MISO=0, tx_ready=1, rx_data=0, rx_done=0, busy=0, FSM=IDLE, all synchronisers at reset = SS_n 1, SCLK CPOL, MOSI 0.
- Pin-to-action latency: SYNC_STAGES+1 clk rising edges (±1 for asynchronous alignment).
  - Sample/shift: the edge is detected on the synchronised SCLK and the action is registered on the next clock edge.
  - rx_done asserts SYNC_STAGES+1 clk edges after the final sample edge at the pin.
  - MISO changes SYNC_STAGES+1 clk edges after a shift edge at the pin.
- Master constraints:
  - SCLK high and low times ≥ SYNC_STAGES+3 clk periods.
  - SS_n fall to first SCLK edge ≥ SYNC_STAGES+3 clk periods.
  - SS_n rise after last SCLK edge ≥ SYNC_STAGES+2 clk periods.
- tx_ready falls the cycle after acceptance and rises the cycle after the buffer is consumed by a load.

## Configuration
- SPI_SLAVE_ERR_EN defined: adds outputs tx_underrun (1 bit, one-cycle pulse when a frame loads zeros because tx_buf was empty) and frame_err (1 bit, one-cycle pulse on SS_n rise mid-frame). Both reset to 0.
- SPI_SLAVE_ERR_EN undefined: neither port exists; behaviour is otherwise identical.

## Structure
- Package spi_pkg: FSM state enum typedef (IDLE, XFER); localparam helpers for edge selection from CPOL/CPHA.
- Sub-module spi_edge_sync: SYNC_STAGES-deep synchroniser for SCLK/MOSI/SS_n; outputs synchronised levels plus one-cycle sample_edge, shift_edge, ss_fall and ss_rise pulses. Parameters: CPOL, CPHA, SYNC_STAGES.
- Top level holds the FSM, bit counter, RX/TX shift registers and transmit buffer.

## Test plan
- Defaults, SCLK half-period 50 clk: master sends 0xF0, 0x0F, 0xAA, 0x55 in separate SS_n frames → rx_data equals each word, exactly one rx_done per frame, busy high only while SS_n is low.
- Defaults: tx_data 0x3C written before SS_n falls, master sends 0xA5 → master captures 0x3C on MISO, rx_data=0xA5, tx_ready returns to 1 at frame start.
- DATA_W=16, CPOL=1, CPHA=1, MSB_FIRST=0: two back-to-back frames under one SS_n, TX words 0x1234 then 0xBEEF, MOSI 0xCAFE then 0x0001 → MISO and rx_data match in LSB-first order, two rx_done pulses.
- Defaults: SS_n raised after 5 bits of 0xFF → no rx_done, rx_data unchanged, frame_err pulses (ERR_EN); the next full frame 0x81 is received correctly.
- Defaults with tx_buf empty: frame sent → MISO all zeros, tx_underrun pulses (ERR_EN).
- rst_n pulsed low mid-frame → all outputs at reset values immediately; the subsequent frame 0x5A is received correctly.
